mpc_demux_14_32_reg: RTL and testbench
======================================

Name: mpc_demux_14_32_reg

Overview:
Registered 1-to-4 demultiplexer with valid/ready handshaking. It is the scatter counterpart of the MPC 4:1 select muxes. It takes a stream of words and steers each word into one of four output lanes, each lane holding one register stage. The lane is chosen by an explicit select or by an internal round-robin index. It feeds per-bank operand buffers in the MPC datapath, for example distributing a vector across four parallel MAC banks.

Parameters:
DATA_WIDTH, 32, width of data words
AUTO_SEL, 0, 0 = lane chosen by din_sel; 1 = lane chosen by internal index (din_sel ignored)

Ports:
ap_clk  input  1  clock; all state updates on rising edge
ap_rst_n  input  1  asynchronous active-low reset
din  input  DATA_WIDTH  input word
din_sel  input  2  target lane (used when AUTO_SEL=0)
din_vld  input  1  input word valid
din_rdy  output  1  block can accept din this cycle
idx_clr  input  1  synchronous clear of the round-robin index
dout0..dout3  output  DATA_WIDTH each  lane data registers
dout0_vld..dout3_vld  output  1 each  lane holds a valid word
dout0_rdy..dout3_rdy  input  1 each  downstream consumes lane word
seq_idx  output  2  current round-robin index (0 when AUTO_SEL=0)
frame_done  output  1  one-cycle pulse after lane 3 accepted in AUTO_SEL=1

Behaviour:
- Reset (ap_rst_n=0, asynchronous): all doutN=0, doutN_vld=0, seq_idx=0, frame_done=0. Any word held in a lane is discarded.
- Target lane T = AUTO_SEL ? seq_idx : din_sel.
- din_rdy = ~doutT_vld | doutT_rdy. This is combinational on din_sel/seq_idx and doutT_vld/doutT_rdy; there is no dependency on din_vld.
- Accept = din_vld & din_rdy. On accept, doutT <= din and doutT_vld <= 1 at the next edge. Latency is 1 cycle.
- Drain: when doutN_vld & doutN_rdy, lane N is consumed.
  - If the lane is not loaded in the same cycle, doutN_vld <= 0 and doutN holds its old value.
- Simultaneous drain and load of the same lane: doutN takes the new word and doutN_vld stays 1. This gives full throughput of 1 word/cycle per lane.
- Stall: while doutN_vld=1 and doutN_rdy=0, doutN must be held stable. A word for lane N is not accepted (din_rdy=0 when T=N). Other lanes are unaffected, but the input stream is in-order, so it blocks until T changes.
- Non-target lanes never change except by their own drain.
- Round-robin (AUTO_SEL=1):
  - On accept, seq_idx increments mod 4 (3 -> 0).
  - frame_done=1 for exactly one cycle, in the cycle after an accept with seq_idx=3; otherwise 0.
  - idx_clr=1: seq_idx <= 0 at the next edge. Lane registers and vld flags are unaffected.
  - idx_clr together with an accept: the word goes to the current seq_idx, then seq_idx <= 0. frame_done still pulses if that accept was at index 3.
- AUTO_SEL=0: seq_idx is held at 0, frame_done is held at 0, and idx_clr is ignored.
- din_vld=0: no state change except drains. din and din_sel are don't-care.
- din_vld must not be gated on din_rdy by the upstream (standard valid/ready). The block does not require din to stay stable while unaccepted, but the upstream normally holds it.

Test Plan:
- Reset mid-stream: lanes 0,2 valid with 0xAAAA0000/0xCCCC0000, assert ap_rst_n=0 asynchronously -> all dout=0, all vld=0 immediately; seq_idx=0.
- Manual select, all dout_rdy=1: send 0x11,0x22,0x33,0x44 with din_sel=3,2,1,0 back-to-back -> dout3=0x11 valid at cycle+1, dout2=0x22 at +2, dout1=0x33 at +3, dout0=0x44 at +4; din_rdy=1 throughout.
- Backpressure: dout1_rdy=0, lane 1 holds 0x5A, din_sel=1, din=0x6B, din_vld=1 -> din_rdy=0 and dout1 stays 0x5A. Raise dout1_rdy -> same cycle accept; next cycle dout1=0x6B, dout1_vld=1 (no bubble).
- Round-robin, AUTO_SEL=1: stream 8 words 0x100..0x107, all rdy=1 -> lanes 0..3 receive 0x100..0x103 then 0x104..0x107; frame_done pulses twice, each one cycle after words 0x103 and 0x107 are accepted.
- idx_clr with accept at seq_idx=2: word goes to lane 2, next seq_idx=0, frame_done stays 0. idx_clr with accept at seq_idx=3: frame_done=1 and seq_idx=0.

Source files
------------

// File: rtl/mpc_demux_14_32_reg.sv
// Registered 1-to-4 demultiplexer with valid/ready handshake on the input and on
// every output lane; the lane is picked by din_sel or by an internal round-robin index.
module mpc_demux_14_32_reg #(
    parameter int DATA_WIDTH = 32,
    parameter bit AUTO_SEL   = 1'b0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [1:0]            din_sel,
    input  logic                  din_vld,
    output logic                  din_rdy,
    input  logic                  idx_clr,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic [DATA_WIDTH-1:0] dout2,
    output logic [DATA_WIDTH-1:0] dout3,
    output logic                  dout0_vld,
    output logic                  dout1_vld,
    output logic                  dout2_vld,
    output logic                  dout3_vld,
    input  logic                  dout0_rdy,
    input  logic                  dout1_rdy,
    input  logic                  dout2_rdy,
    input  logic                  dout3_rdy,
    output logic [1:0]            seq_idx,
    output logic                  frame_done
);

    logic [DATA_WIDTH-1:0] lane_data [4];
    logic [3:0]            lane_vld;
    logic [3:0]            lane_rdy;
    logic [3:0]            load;
    logic [1:0]            target;
    logic [1:0]            idx;
    logic                  accept;
    logic                  frame;

    assign lane_rdy = {dout3_rdy, dout2_rdy, dout1_rdy, dout0_rdy};
    assign target   = AUTO_SEL ? idx : din_sel;

    // A lane can take a word when empty or when its current word leaves this cycle.
    assign din_rdy  = ~lane_vld[target] | lane_rdy[target];
    assign accept   = din_vld & din_rdy;

    always_comb begin
        load         = '0;
        load[target] = accept;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int n = 0; n < 4; n++) begin
                lane_data[n] <= '0;
            end
            lane_vld <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (load[n]) begin
                    lane_data[n] <= din;
                    lane_vld[n]  <= 1'b1;
                end else if (lane_vld[n] && lane_rdy[n]) begin
                    lane_vld[n]  <= 1'b0;
                end
            end
        end
    end

    // Index advances only on accept; a clear wins over the increment.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            idx   <= 2'd0;
            frame <= 1'b0;
        end else if (!AUTO_SEL) begin
            idx   <= 2'd0;
            frame <= 1'b0;
        end else begin
            frame <= accept & (idx == 2'd3);
            if (idx_clr) begin
                idx <= 2'd0;
            end else if (accept) begin
                idx <= idx + 2'd1;
            end
        end
    end

    assign dout0      = lane_data[0];
    assign dout1      = lane_data[1];
    assign dout2      = lane_data[2];
    assign dout3      = lane_data[3];
    assign dout0_vld  = lane_vld[0];
    assign dout1_vld  = lane_vld[1];
    assign dout2_vld  = lane_vld[2];
    assign dout3_vld  = lane_vld[3];
    assign seq_idx    = idx;
    assign frame_done = frame;

endmodule

// File: tb/tb_mpc_demux_14_32_reg.sv
// Bench for mpc_demux_14_32_reg: a manual-select and an auto-select instance share
// the same stimulus and are compared against a lane-level reference model.
module tb_mpc_demux_14_32_reg;

    logic        ap_clk;
    logic        ap_rst_n;
    logic [31:0] din;
    logic [1:0]  din_sel;
    logic        din_vld;
    logic        idx_clr;
    logic [3:0]  lrdy;

    logic [31:0] dat_man [4];
    logic [31:0] dat_auto [4];
    logic [3:0]  vld_man, vld_auto;
    logic        rdy_man, rdy_auto;
    logic [1:0]  seq_man, seq_auto;
    logic        fd_man, fd_auto;

    int total = 0;
    int bad   = 0;

    // Reference state: [0] = manual instance, [1] = auto instance
    logic [31:0] m_data [2][4];
    bit          m_vld  [2][4];
    int          m_idx  [2];
    bit          m_fd   [2];

    mpc_demux_14_32_reg #(.DATA_WIDTH(32), .AUTO_SEL(1'b0)) u_man (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .din(din), .din_sel(din_sel),
        .din_vld(din_vld), .din_rdy(rdy_man), .idx_clr(idx_clr),
        .dout0(dat_man[0]), .dout1(dat_man[1]), .dout2(dat_man[2]), .dout3(dat_man[3]),
        .dout0_vld(vld_man[0]), .dout1_vld(vld_man[1]), .dout2_vld(vld_man[2]), .dout3_vld(vld_man[3]),
        .dout0_rdy(lrdy[0]), .dout1_rdy(lrdy[1]), .dout2_rdy(lrdy[2]), .dout3_rdy(lrdy[3]),
        .seq_idx(seq_man), .frame_done(fd_man)
    );

    mpc_demux_14_32_reg #(.DATA_WIDTH(32), .AUTO_SEL(1'b1)) u_auto (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .din(din), .din_sel(din_sel),
        .din_vld(din_vld), .din_rdy(rdy_auto), .idx_clr(idx_clr),
        .dout0(dat_auto[0]), .dout1(dat_auto[1]), .dout2(dat_auto[2]), .dout3(dat_auto[3]),
        .dout0_vld(vld_auto[0]), .dout1_vld(vld_auto[1]), .dout2_vld(vld_auto[2]), .dout3_vld(vld_auto[3]),
        .dout0_rdy(lrdy[0]), .dout1_rdy(lrdy[1]), .dout2_rdy(lrdy[2]), .dout3_rdy(lrdy[3]),
        .seq_idx(seq_auto), .frame_done(fd_auto)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 4; n++) begin
                m_data[d][n] = '0;
                m_vld[d][n]  = 1'b0;
            end
            m_idx[d] = 0;
            m_fd[d]  = 1'b0;
        end
    endtask

    task automatic set_in(input bit v, input logic [1:0] s, input logic [31:0] w,
                          input bit c, input logic [3:0] r);
        din_vld = v;
        din_sel = s;
        din     = w;
        idx_clr = c;
        lrdy    = r;
    endtask

    // Compare every output against the model, then advance the model by one clock.
    task automatic step();
        #1;
        for (int d = 0; d < 2; d++) begin
            int t;
            bit r;
            bit a;
            for (int n = 0; n < 4; n++) begin
                check_eq($sformatf("d%0d.dout%0d", d, n),
                         (d == 1) ? dat_auto[n] : dat_man[n], m_data[d][n]);
                check_eq($sformatf("d%0d.vld%0d", d, n),
                         (d == 1) ? vld_auto[n] : vld_man[n], m_vld[d][n]);
            end
            check_eq($sformatf("d%0d.seq_idx", d), (d == 1) ? seq_auto : seq_man, m_idx[d]);
            check_eq($sformatf("d%0d.frame_done", d), (d == 1) ? fd_auto : fd_man, m_fd[d]);
            t = (d == 1) ? m_idx[1] : int'(din_sel);
            r = !m_vld[d][t] || lrdy[t];
            a = din_vld && r;
            check_eq($sformatf("d%0d.din_rdy", d), (d == 1) ? rdy_auto : rdy_man, r);
            for (int n = 0; n < 4; n++) begin
                if (a && n == t) begin
                    m_data[d][n] = din;
                    m_vld[d][n]  = 1'b1;
                end else if (m_vld[d][n] && lrdy[n]) begin
                    m_vld[d][n]  = 1'b0;
                end
            end
            if (d == 1) begin
                m_fd[1]  = a && (m_idx[1] == 3);
                m_idx[1] = idx_clr ? 0 : (a ? (m_idx[1] + 1) % 4 : m_idx[1]);
            end
        end
        @(negedge ap_clk);
    endtask

    initial begin
        ap_rst_n = 1'b0;
        set_in(0, 2'd0, 32'd0, 0, 4'h0);
        model_reset();
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        step();

        // Load lanes 0 and 2, then reset asynchronously mid-cycle
        set_in(1, 2'd0, 32'hAAAA0000, 0, 4'h0);
        step();
        set_in(1, 2'd2, 32'hCCCC0000, 0, 4'h0);
        step();
        check_eq("pre_rst.dout0", dat_man[0], 32'hAAAA0000);
        check_eq("pre_rst.dout2", dat_man[2], 32'hCCCC0000);
        #2 ap_rst_n = 1'b0;
        #1;
        for (int n = 0; n < 4; n++) begin
            check_eq($sformatf("rst.man.dout%0d", n), dat_man[n], 32'd0);
            check_eq($sformatf("rst.auto.dout%0d", n), dat_auto[n], 32'd0);
        end
        check_eq("rst.man.vld", vld_man, 4'h0);
        check_eq("rst.auto.vld", vld_auto, 4'h0);
        check_eq("rst.auto.seq_idx", seq_auto, 2'd0);
        model_reset();
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        set_in(0, 2'd0, 32'd0, 0, 4'hF);
        step();

        // Manual select, back-to-back, lanes 3..0
        for (int i = 0; i < 4; i++) begin
            set_in(1, 2'(3 - i), 32'(8'h11 * (i + 1)), 0, 4'hF);
            step();
            check_eq("man_seq.dout", dat_man[3 - i], 32'(8'h11 * (i + 1)));
            check_eq("man_seq.vld", vld_man[3 - i], 1'b1);
        end

        // Backpressure on lane 1, then release without a bubble
        set_in(1, 2'd1, 32'h5A, 0, 4'b1101);
        step();
        set_in(1, 2'd1, 32'h6B, 0, 4'b1101);
        #1 check_eq("bp.din_rdy", rdy_man, 1'b0);
        step();
        check_eq("bp.hold", dat_man[1], 32'h5A);
        set_in(1, 2'd1, 32'h6B, 0, 4'hF);
        #1 check_eq("bp.release_rdy", rdy_man, 1'b1);
        step();
        check_eq("bp.new", dat_man[1], 32'h6B);
        check_eq("bp.vld", vld_man[1], 1'b1);

        // Round-robin stream of eight words
        set_in(0, 2'd0, 32'd0, 1, 4'hF);
        step();
        for (int k = 0; k < 8; k++) begin
            set_in(1, 2'd0, 32'h100 + 32'(k), 0, 4'hF);
            step();
            check_eq("rr.lane", dat_auto[k % 4], 32'h100 + 32'(k));
            check_eq("rr.frame_done", fd_auto, (k % 4) == 3);
        end

        // idx_clr together with an accept at index 2, then at index 3
        set_in(0, 2'd0, 32'd0, 1, 4'hF);
        step();
        for (int k = 0; k < 2; k++) begin
            set_in(1, 2'd0, 32'h1F0 + 32'(k), 0, 4'hF);
            step();
        end
        set_in(1, 2'd0, 32'h200, 1, 4'hF);
        step();
        check_eq("clr2.lane2", dat_auto[2], 32'h200);
        check_eq("clr2.seq_idx", seq_auto, 2'd0);
        check_eq("clr2.frame_done", fd_auto, 1'b0);
        for (int k = 0; k < 3; k++) begin
            set_in(1, 2'd0, 32'h2F0 + 32'(k), 0, 4'hF);
            step();
        end
        set_in(1, 2'd0, 32'h300, 1, 4'hF);
        step();
        check_eq("clr3.lane3", dat_auto[3], 32'h300);
        check_eq("clr3.seq_idx", seq_auto, 2'd0);
        check_eq("clr3.frame_done", fd_auto, 1'b1);
        set_in(0, 2'd0, 32'd0, 0, 4'hF);
        step();

        // Randomized traffic with random backpressure and clears
        for (int c = 0; c < 400; c++) begin
            set_in($urandom_range(0, 3) != 0, 2'($urandom), 32'($urandom),
                   $urandom_range(0, 7) == 0, 4'($urandom));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
